// File: rtl/sw_in_port.sv
`default_nettype none
// ============================================================================
// sw_in_port : switch input port - packet FIFO, destination decode, req/ack
//              handshake toward the output arbiters, streaming onto the bus.
// Optional   : `SW_PKT_CNT_EN adds pkt_cnt, a count of forwarded packets.
// Revision   : 1.0
// ============================================================================
module sw_in_port #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         req0,
    output logic         req1,
    output logic         req2,
    output logic         req3,
    input  logic         ack0,
    input  logic         ack1,
    input  logic         ack2,
    input  logic         ack3,
`ifdef SW_PKT_CNT_EN
    output logic [15:0]  pkt_cnt,
`endif
    output logic [W-1:0] sw_data,
    output logic         sw_last,
    output logic         sw_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [1:0]    dest_q, dest_d;
    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic          w_full, w_empty, w_push, w_pop;
    logic [W-1:0]  w_head_data;
    logic          w_head_last;
    logic [3:0]    w_ack, w_req;
    logic          w_ack_dest;

    assign w_full     = (count_q == c_DEPTH);
    assign w_empty    = (count_q == '0);
    assign in_ready   = !w_full;
    // A full FIFO refuses input even when a pop frees a slot this cycle.
    assign w_push     = in_valid && !w_full;
    assign w_pop      = sw_valid;
    assign {w_head_last, w_head_data} = mem_q[rd_ptr_q];
    assign w_ack      = {ack3, ack2, ack1, ack0};
    assign w_ack_dest = w_ack[dest_q];
    assign {req3, req2, req1, req0} = w_req;
    assign sw_data    = sw_valid ? w_head_data : '0;
    assign sw_last    = sw_valid && w_head_last;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (AW)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (AW)'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dest_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        w_req    = 4'b0000;
        sw_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    dest_d  = w_head_data[1:0];
                    state_d = S_REQ;
                end
            end
            // The grant cycle already carries the first word, so REQ and
            // SEND share the streaming logic.
            S_REQ, S_SEND: begin
                w_req[dest_q] = 1'b1;
                if (w_ack_dest) begin
                    sw_valid = !w_empty;
                    state_d  = (sw_valid && w_head_last) ? S_GAP : S_SEND;
                end
            end
            S_GAP: begin
                if (!w_empty) begin
                    dest_d  = w_head_data[1:0];
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SW_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= 16'd0;
        end else if (w_pop && w_head_last) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_in_port.sv
`default_nettype none
// ============================================================================
// tb_sw_in_port : directed self-checking bench for sw_in_port.
// Revision      : 1.0
// ============================================================================
module tb_sw_in_port;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       req0, req1, req2, req3;
    logic       ack0, ack1, ack2, ack3;
    logic [7:0] sw_data;
    logic       sw_last;
    logic       sw_valid;
`ifdef SW_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // follow=1 models a registered arbiter granting whatever it saw requested
    logic       follow;
    logic [3:0] ack_man;
    logic [3:0] ack_f;
    logic [3:0] req_v;
    logic [13:0] obs;

    assign req_v = {req3, req2, req1, req0};
    assign {ack3, ack2, ack1, ack0} = follow ? ack_f : ack_man;
    assign obs = {req_v, sw_valid, sw_last, sw_data};

    always @(posedge clk) ack_f <= rst ? 4'b0000 : req_v;

    sw_in_port #(.W(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .req0     (req0),
        .req1     (req1),
        .req2     (req2),
        .req3     (req3),
        .ack0     (ack0),
        .ack1     (ack1),
        .ack2     (ack2),
        .ack3     (ack3),
`ifdef SW_PKT_CNT_EN
        .pkt_cnt  (pkt_cnt),
`endif
        .sw_data  (sw_data),
        .sw_last  (sw_last),
        .sw_valid (sw_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        follow = 1'b0; ack_man = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({obs, in_ready} !== {14'h0000, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got req=%b v=%b l=%b d=%h rdy=%b, want req=0000 v=0 l=0 d=00 rdy=1",
                         i, req_v, sw_valid, sw_last, sw_data, in_ready);
            end
        end
`ifdef SW_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt);
        end
`endif
    endtask

    // stim = {ack_man, in_valid, in_last, in_data}; exp = {req, valid, last, data}
    task automatic test_single();
        logic [13:0] stim [8];
        logic [13:0] exp  [8];
        stim = '{{4'b0000, 1'b1, 1'b0, 8'h02}, {4'b0000, 1'b1, 1'b0, 8'hAA},
                 {4'b0000, 1'b1, 1'b1, 8'hBB}, 14'h0000, 14'h0000, 14'h0000,
                 14'h0000, 14'h0000};
        exp  = '{14'h0000, 14'h0000,
                 {4'b0100, 1'b0, 1'b0, 8'h00}, {4'b0100, 1'b1, 1'b0, 8'h02},
                 {4'b0100, 1'b1, 1'b0, 8'hAA}, {4'b0100, 1'b1, 1'b1, 8'hBB},
                 14'h0000, 14'h0000};
        follow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {ack_man, in_valid, in_last, in_data} = stim[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL single[%0d]: got req=%b v=%b l=%b d=%h, want req=%b v=%b l=%b d=%h",
                         i, req_v, sw_valid, sw_last, sw_data,
                         exp[i][13:10], exp[i][9], exp[i][8], exp[i][7:0]);
            end
        end
    endtask

    task automatic test_delayed_grant();
        logic [13:0] stim [13];
        logic [13:0] exp  [13];
        stim = '{{4'b0000, 1'b1, 1'b0, 8'h01}, {4'b0000, 1'b1, 1'b0, 8'h11},
                 {4'b0000, 1'b1, 1'b1, 8'h22}, {4'b0001, 10'h000},
                 {4'b1000, 10'h000}, {4'b0001, 10'h000}, {4'b0000, 10'h000},
                 {4'b0010, 10'h000}, {4'b0000, 10'h000}, {4'b1010, 10'h000},
                 {4'b0010, 10'h000}, {4'b0010, 10'h000}, {4'b0000, 10'h000}};
        exp  = '{14'h0000, 14'h0000,
                 {4'b0010, 10'h000}, {4'b0010, 10'h000}, {4'b0010, 10'h000},
                 {4'b0010, 10'h000}, {4'b0010, 10'h000},
                 {4'b0010, 1'b1, 1'b0, 8'h01}, {4'b0010, 10'h000},
                 {4'b0010, 1'b1, 1'b0, 8'h11}, {4'b0010, 1'b1, 1'b1, 8'h22},
                 14'h0000, 14'h0000};
        follow = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            {ack_man, in_valid, in_last, in_data} = stim[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL delayed_grant[%0d]: got req=%b v=%b l=%b d=%h, want req=%b v=%b l=%b d=%h",
                         i, req_v, sw_valid, sw_last, sw_data,
                         exp[i][13:10], exp[i][9], exp[i][8], exp[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] stim [9];
        logic [13:0] exp  [9];
        stim = '{{4'b0000, 1'b1, 1'b1, 8'h03}, {4'b0000, 1'b1, 1'b1, 8'h07},
                 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000,
                 14'h0000};
        exp  = '{14'h0000, 14'h0000,
                 {4'b1000, 10'h000}, {4'b1000, 1'b1, 1'b1, 8'h03}, 14'h0000,
                 {4'b1000, 10'h000}, {4'b1000, 1'b1, 1'b1, 8'h07}, 14'h0000,
                 14'h0000};
        follow = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            {ack_man, in_valid, in_last, in_data} = stim[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got req=%b v=%b l=%b d=%h, want req=%b v=%b l=%b d=%h",
                         i, req_v, sw_valid, sw_last, sw_data,
                         exp[i][13:10], exp[i][9], exp[i][8], exp[i][7:0]);
            end
        end
    endtask

    task automatic test_fifo_full();
        follow = 1'b0; ack_man = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(8'h10 + k); in_last = (k == 15);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want 1", k, in_ready);
            end
        end
        @(negedge clk);
        in_data = 8'h55; in_last = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_after_16: in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({req_v, in_ready, sw_valid} !== 6'b0001_00) begin
            errors++;
            $display("FAIL full_hold: got req=%b rdy=%b v=%b want req=0001 rdy=0 v=0",
                     req_v, in_ready, sw_valid);
        end
        ack_man = 4'b0001;
        #1;
        checks++;
        if ({sw_valid, sw_last, sw_data} !== {1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL first_pop: got v=%b l=%b d=%h want v=1 l=0 d=10",
                     sw_valid, sw_last, sw_data);
        end
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            #1;
            if (k == 1) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_pop: got %b want 1", in_ready);
                end
            end
            checks++;
            if ({sw_valid, sw_last, sw_data} !== {1'b1, (k == 15), 8'(8'h10 + k)}) begin
                errors++;
                $display("FAIL drain[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         k, sw_valid, sw_last, sw_data, (k == 15), 8'(8'h10 + k));
            end
        end
        @(negedge clk);
        ack_man = 4'b0000;
        #1;
        checks++;
        if ({req_v, sw_valid} !== 5'b0000_0) begin
            errors++;
            $display("FAIL full_gap: got req=%b v=%b want req=0000 v=0", req_v, sw_valid);
        end
        @(negedge clk);
        ack_man = 4'b0010;
        #1;
        checks++;
        if (obs !== {4'b0010, 1'b1, 1'b1, 8'h55}) begin
            errors++;
            $display("FAIL word17: got req=%b v=%b l=%b d=%h want req=0010 v=1 l=1 d=55",
                     req_v, sw_valid, sw_last, sw_data);
        end
        @(negedge clk);
        ack_man = 4'b0000;
        @(negedge clk);
        #1;
        checks++;
        if ({obs, in_ready} !== {14'h0000, 1'b1}) begin
            errors++;
            $display("FAIL full_idle: got req=%b v=%b rdy=%b want req=0000 v=0 rdy=1",
                     req_v, sw_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] words [4];
        logic [8:0] want  [3];
        logic [8:0] got   [3];
        int         n;
        words = '{8'h06, 8'h01, 8'h02, 8'h03};
        want  = '{{1'b0, 8'h01}, {1'b1, 8'h44}, {1'b1, 8'h0E}};
        follow = 1'b0; ack_man = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = words[i]; in_last = (i == 3);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        checks++;
        if ({sw_valid, sw_data} !== {1'b1, 8'h02}) begin
            errors++;
            $display("FAIL pre_reset_send: got v=%b d=%h want v=1 d=02", sw_valid, sw_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_v, sw_valid, in_ready} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL post_reset: got req=%b v=%b rdy=%b want req=0000 v=0 rdy=1",
                     req_v, sw_valid, in_ready);
        end
`ifdef SW_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_pkt_cnt: got %0d want 0", pkt_cnt);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if ({req_v, sw_valid} !== 5'b0000_0) begin
            errors++;
            $display("FAIL flushed: got req=%b v=%b want req=0000 v=0", req_v, sw_valid);
        end
        ack_man = 4'b0000; follow = 1'b1;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            in_valid = (c < 3);
            in_data  = (c == 0) ? 8'h01 : (c == 1) ? 8'h44 : (c == 2) ? 8'h0E : 8'h00;
            in_last  = (c == 1) || (c == 2);
            #1;
            if (sw_valid) begin
                if (n < 3) got[n] = {sw_last, sw_data};
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL after_reset_count: got %0d words want 3", n);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < n) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL after_reset_word[%0d]: got l=%b d=%h want l=%b d=%h",
                             i, got[i][8], got[i][7:0], want[i][8], want[i][7:0]);
                end
            end
        end
`ifdef SW_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd2) begin
            errors++;
            $display("FAIL pkt_cnt_two: got %0d want 2", pkt_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        follow = 1'b0; ack_man = 4'b0000;
        test_reset();
        test_single();
        test_delayed_grant();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
